// File: rtl/ccff_chain_loader_if.sv
// rtl/ccff_chain_loader_if.sv - word stream handshake between bitstream source and chain loader
interface ccff_chain_loader_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] word_in;
    logic              word_valid;
    logic              word_ready;

    modport master (output word_in, output word_valid, input word_ready);
    modport slave  (input word_in, input word_valid, output word_ready);
endinterface

// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - probes the configuration chain length, then streams the bitstream into it
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 16,
    parameter int WORD_W    = 8
) (
    input  logic               prog_clk,
    input  logic               pReset_n,
    input  logic               start,
    ccff_chain_loader_if.slave word_if,
    output logic               ccff_head,
    output logic               prog_clk_en,
    input  logic               ccff_tail,
    output logic               busy,
    output logic               done,
    output logic               len_err
);
    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam int RW = $clog2(WORD_W + 1);
    localparam logic [CW-1:0] LEN    = CW'(CHAIN_LEN);
    localparam logic [RW-1:0] REFILL = RW'(WORD_W - 1);

    typedef enum logic [1:0] {IDLE, PROBE, LOAD, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic [RW-1:0]     rem_q, rem_d;
    logic              head_d, en_d, err_d;
    logic              word_ready;

    // A word is taken only into an empty buffer; its bit 0 is issued in the same edge
    assign word_ready         = (state_q == LOAD) && (rem_q == '0) && (cnt_q < LEN);
    assign word_if.word_ready = word_ready;
    assign busy               = (state_q != IDLE);
    assign done               = (state_q == DONE);

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            rem_q       <= '0;
            ccff_head   <= 1'b0;
            prog_clk_en <= 1'b0;
            len_err     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            rem_q       <= rem_d;
            ccff_head   <= head_d;
            prog_clk_en <= en_d;
            len_err     <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        rem_d   = rem_q;
        head_d  = 1'b0;
        en_d    = 1'b0;
        err_d   = len_err;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = PROBE;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    head_d  = 1'b1;
                    en_d    = 1'b1;
                end
            end
            PROBE: begin
                // cnt_q counts completed shifts, so ccff_tail here reflects cnt_q shifts
                if ((cnt_q != '0) && (cnt_q < LEN) && ccff_tail) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (prog_clk_en) begin
                    cnt_d = cnt_q + CW'(1);
                    en_d  = (cnt_d != LEN);
                end else if (ccff_tail) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (cnt_q == LEN) begin
                    state_d = DONE;
                    data_d  = '0;
                    rem_d   = '0;
                end else if (rem_q != '0) begin
                    head_d = data_q[0];
                    en_d   = 1'b1;
                    data_d = data_q >> 1;
                    rem_d  = rem_q - RW'(1);
                    cnt_d  = cnt_q + CW'(1);
                end else if (word_ready && word_if.word_valid) begin
                    head_d = word_if.word_in[0];
                    en_d   = 1'b1;
                    data_d = word_if.word_in >> 1;
                    rem_d  = REFILL;
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb/tb_ccff_chain_loader.sv - randomized bench for ccff_chain_loader against a serial chain model
module tb_ccff_chain_loader;
    localparam int LA = 16;
    localparam int LB = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, sel, chain_clr;
    logic [7:0] wdata;
    logic       wvalid;
    int         n_cmp = 0;
    int         n_fail = 0;
    int         nff_a = LA;
    logic [7:0] words[$];

    ccff_chain_loader_if #(.WORD_W(8)) if_a ();
    ccff_chain_loader_if #(.WORD_W(8)) if_b ();
    assign if_a.word_in    = wdata;
    assign if_a.word_valid = wvalid & ~sel;
    assign if_b.word_in    = wdata;
    assign if_b.word_valid = wvalid & sel;

    logic head_a, pce_a, tail_a, busy_a, done_a, err_a;
    logic head_b, pce_b, tail_b, busy_b, done_b, err_b;

    ccff_chain_loader #(.CHAIN_LEN(LA), .WORD_W(8)) dut_a (
        .prog_clk(clk), .pReset_n(rst_n), .start(start & ~sel), .word_if(if_a),
        .ccff_head(head_a), .prog_clk_en(pce_a), .ccff_tail(tail_a),
        .busy(busy_a), .done(done_a), .len_err(err_a));

    ccff_chain_loader #(.CHAIN_LEN(LB), .WORD_W(8)) dut_b (
        .prog_clk(clk), .pReset_n(rst_n), .start(start & sel), .word_if(if_b),
        .ccff_head(head_b), .prog_clk_en(pce_b), .ccff_tail(tail_b),
        .busy(busy_b), .done(done_b), .len_err(err_b));

    // Chain models: bit 0 is the FF nearest the head; the tail is FF nff-1
    logic [63:0] chain_a, chain_b;
    always @(posedge clk) begin
        if (chain_clr) chain_a <= '0;
        else if (pce_a) chain_a <= {chain_a[62:0], head_a};
    end
    always @(posedge clk) begin
        if (chain_clr) chain_b <= '0;
        else if (pce_b) chain_b <= {chain_b[62:0], head_b};
    end
    assign tail_a = chain_a[6'(nff_a - 1)];
    assign tail_b = chain_b[LB-1];

    logic        head_s, pce_s, busy_s, done_s, err_s, ready_s;
    logic [63:0] chain_s;
    assign head_s  = sel ? head_b : head_a;
    assign pce_s   = sel ? pce_b : pce_a;
    assign busy_s  = sel ? busy_b : busy_a;
    assign done_s  = sel ? done_b : done_a;
    assign err_s   = sel ? err_b : err_a;
    assign ready_s = sel ? if_b.word_ready : if_a.word_ready;
    assign chain_s = sel ? chain_b : chain_a;

    int   p_nsh, p_nhead;
    logic p_first_head, p_load;
    int   r_nsh, r_first, r_last, r_done_cyc, r_ndone, r_acc, r_stall_pce;
    logic r_stall_same, r_timeout;

    // The first streamed bit lands nearest the tail: chain[n-1-i] = stream bit i
    function automatic logic [63:0] exp_chain(input int n);
        logic [63:0] r;
        logic [7:0]  w;
        r = '0;
        for (int i = 0; i < n; i++) begin
            w = words[i / 8];
            r[n - 1 - i] = w[i % 8];
        end
        return r;
    endfunction

    function automatic logic [63:0] lo_mask(input int n);
        return (64'd1 << n) - 64'd1;
    endfunction

    task automatic run_probe(input int nff, input int restart_at);
        @(negedge clk);
        chain_clr = 1'b1; nff_a = nff; wvalid = 1'b0;
        @(negedge clk);
        chain_clr = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        p_nsh = 0; p_nhead = 0; p_first_head = 1'b0; p_load = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (pce_s) begin
                p_nsh++;
                if (p_nsh == 1) p_first_head = head_s;
            end
            if (head_s) p_nhead++;
            if (ready_s) begin p_load = 1'b1; break; end
            if (!busy_s) break;
            start = (c == restart_at);
            @(negedge clk);
        end
        start = 1'b0;
        n_cmp++; if (busy_s && !p_load) begin n_fail++; $display("FAIL probe_timeout busy=%0b load=%0b exp=settled", busy_s, p_load); end
    endtask

    task automatic run_load(input int stall_word, input int gap_pct, input logic hold_start);
        int          cyc, idx, stall_c;
        logic        valid, xfer, in_stall;
        logic [63:0] snap;
        cyc = 0; idx = 0; stall_c = -1; snap = '0;
        r_nsh = 0; r_first = -1; r_last = -1; r_done_cyc = -1; r_ndone = 0;
        r_stall_pce = 0; r_stall_same = 1'b0; r_timeout = 1'b1;
        while (cyc < 400) begin
            if (pce_s) begin
                r_nsh++;
                if (r_first < 0) r_first = cyc;
                r_last = cyc;
            end
            if (done_s) begin r_ndone++; r_done_cyc = cyc; end
            if (r_ndone > 0 && !busy_s) begin r_timeout = 1'b0; break; end
            if (stall_word >= 0 && stall_c < 0 && idx == stall_word && ready_s) stall_c = cyc;
            if (stall_c >= 0) begin
                if (cyc > stall_c && cyc <= stall_c + 5 && pce_s) r_stall_pce++;
                if (cyc == stall_c + 1) snap = chain_s;
                if (cyc == stall_c + 6) r_stall_same = (chain_s == snap);
            end
            in_stall = (stall_c >= 0) && (cyc < stall_c + 5);
            valid = (idx < words.size()) && !in_stall &&
                    (gap_pct == 0 || int'($urandom_range(99)) >= gap_pct);
            wdata  = valid ? words[idx] : 8'($urandom);
            wvalid = valid;
            start  = hold_start;
            xfer   = valid && ready_s;
            @(posedge clk);
            if (xfer) idx++;
            @(negedge clk);
            cyc++;
        end
        wvalid = 1'b0; start = 1'b0; r_acc = idx;
        n_cmp++; if (r_timeout) begin n_fail++; $display("FAIL load_timeout shifts=%0d done=%0d exp=completion", r_nsh, r_ndone); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; wvalid = 1'b0; wdata = '0; sel = 1'b0; chain_clr = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if ({head_a, pce_a} !== 2'b00) begin n_fail++; $display("FAIL rst_head_pce got=%b exp=00", {head_a, pce_a}); end
        n_cmp++; if (if_a.word_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%b exp=0", if_a.word_ready); end
        n_cmp++; if ({busy_a, done_a, err_a} !== 3'b000) begin n_fail++; $display("FAIL rst_status got=%b exp=000", {busy_a, done_a, err_a}); end
        n_cmp++; if ({head_b, pce_b, if_b.word_ready, busy_b, done_b, err_b} !== 6'b0) begin n_fail++; $display("FAIL rst_dut_b got=%b exp=000000", {head_b, pce_b, if_b.word_ready, busy_b, done_b, err_b}); end
        rst_n = 1'b1;
        @(negedge clk);
        chain_clr = 1'b0;
    endtask

    task automatic test_probe_ok();
        sel = 1'b0;
        run_probe(LA, 4);
        n_cmp++; if (p_nsh !== LA) begin n_fail++; $display("FAIL probe_shifts got=%0d exp=%0d", p_nsh, LA); end
        n_cmp++; if (p_nhead !== 1 || p_first_head !== 1'b1) begin n_fail++; $display("FAIL probe_head got=%0d/%b exp=1/1", p_nhead, p_first_head); end
        n_cmp++; if (p_load !== 1'b1 || err_s !== 1'b0) begin n_fail++; $display("FAIL probe_ok load=%b err=%b exp=1/0", p_load, err_s); end
    endtask

    task automatic test_back_to_back();
        words = '{8'hA5, 8'h3C};
        run_load(-1, 0, 1'b1);
        n_cmp++; if (r_nsh !== LA || r_last - r_first + 1 !== LA) begin n_fail++; $display("FAIL b2b_shifts got=%0d span=%0d exp=%0d", r_nsh, r_last - r_first + 1, LA); end
        n_cmp++; if (r_ndone !== 1 || r_done_cyc !== r_last + 1) begin n_fail++; $display("FAIL b2b_done got=%0d@%0d exp=1@%0d", r_ndone, r_done_cyc, r_last + 1); end
        n_cmp++; if ((chain_s & lo_mask(LA)) !== exp_chain(LA)) begin n_fail++; $display("FAIL b2b_chain got=%h exp=%h", chain_s & lo_mask(LA), exp_chain(LA)); end
        n_cmp++; if (chain_s[LA-1] !== 1'b1 || chain_s[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_ends got=%b%b exp=10", chain_s[LA-1], chain_s[0]); end
        n_cmp++; if (r_acc !== 2) begin n_fail++; $display("FAIL b2b_accepted got=%0d exp=2", r_acc); end
    endtask

    task automatic check_quiet(input string name);
        int bad;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (pce_s || ready_s || busy_s) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL %s_quiet got=%0d active cycles exp=0", name, bad); end
    endtask

    task automatic test_short_chain();
        int nff;
        sel = 1'b0;
        for (int it = 0; it < 4; it++) begin
            nff = (it == 0) ? LA - 1 : int'($urandom_range(2, LA - 2));
            run_probe(nff, -1);
            n_cmp++; if (err_s !== 1'b1 || busy_s !== 1'b0 || p_load !== 1'b0) begin n_fail++; $display("FAIL short_err nff=%0d err=%b busy=%b load=%b exp=1/0/0", nff, err_s, busy_s, p_load); end
            n_cmp++; if (p_nsh < nff || p_nsh > nff + 1) begin n_fail++; $display("FAIL short_shifts nff=%0d got=%0d exp=%0d..%0d", nff, p_nsh, nff, nff + 1); end
        end
        check_quiet("short");
    endtask

    task automatic test_long_chain();
        sel = 1'b0;
        run_probe(LA + 1, -1);
        n_cmp++; if (p_nsh !== LA) begin n_fail++; $display("FAIL long_shifts got=%0d exp=%0d", p_nsh, LA); end
        n_cmp++; if (err_s !== 1'b1 || busy_s !== 1'b0 || p_load !== 1'b0) begin n_fail++; $display("FAIL long_err err=%b busy=%b load=%b exp=1/0/0", err_s, busy_s, p_load); end
    endtask

    task automatic test_stall();
        sel = 1'b0;
        run_probe(LA, -1);
        n_cmp++; if (err_s !== 1'b0 || p_load !== 1'b1) begin n_fail++; $display("FAIL stall_probe err=%b load=%b exp=0/1", err_s, p_load); end
        words = '{8'($urandom), 8'($urandom)};
        run_load(1, 0, 1'b0);
        n_cmp++; if (r_stall_pce !== 0) begin n_fail++; $display("FAIL stall_pce got=%0d exp=0", r_stall_pce); end
        n_cmp++; if (r_stall_same !== 1'b1) begin n_fail++; $display("FAIL stall_hold got=%b exp=1", r_stall_same); end
        n_cmp++; if ((chain_s & lo_mask(LA)) !== exp_chain(LA) || r_nsh !== LA) begin n_fail++; $display("FAIL stall_chain got=%h/%0d exp=%h/%0d", chain_s & lo_mask(LA), r_nsh, exp_chain(LA), LA); end
    endtask

    task automatic test_random();
        sel = 1'b0;
        for (int it = 0; it < 4; it++) begin
            run_probe(LA, -1);
            words = '{8'($urandom), 8'($urandom)};
            run_load(-1, 40, 1'b0);
            n_cmp++; if ((chain_s & lo_mask(LA)) !== exp_chain(LA)) begin n_fail++; $display("FAIL rand_chain it=%0d got=%h exp=%h", it, chain_s & lo_mask(LA), exp_chain(LA)); end
            n_cmp++; if (r_nsh !== LA || r_ndone !== 1) begin n_fail++; $display("FAIL rand_count it=%0d got=%0d/%0d exp=%0d/1", it, r_nsh, r_ndone, LA); end
        end
    endtask

    task automatic test_partial_word();
        sel = 1'b1;
        run_probe(LB, -1);
        n_cmp++; if (p_nsh !== LB || p_load !== 1'b1) begin n_fail++; $display("FAIL part_probe got=%0d/%b exp=%0d/1", p_nsh, p_load, LB); end
        words = '{8'hFF, 8'h0F, 8'hAA};
        run_load(-1, 0, 1'b0);
        n_cmp++; if (r_nsh !== LB || r_acc !== 2) begin n_fail++; $display("FAIL part_shifts got=%0d acc=%0d exp=%0d acc=2", r_nsh, r_acc, LB); end
        n_cmp++; if (r_done_cyc !== r_last + 1) begin n_fail++; $display("FAIL part_done got=%0d exp=%0d", r_done_cyc, r_last + 1); end
        n_cmp++; if ((chain_s & lo_mask(LB)) !== exp_chain(LB)) begin n_fail++; $display("FAIL part_chain got=%h exp=%h", chain_s & lo_mask(LB), exp_chain(LB)); end
        run_probe(LB, -1);
        words = '{8'($urandom), 8'($urandom), 8'($urandom)};
        run_load(-1, 30, 1'b0);
        n_cmp++; if ((chain_s & lo_mask(LB)) !== exp_chain(LB) || r_acc !== 2) begin n_fail++; $display("FAIL part_rand got=%h acc=%0d exp=%h acc=2", chain_s & lo_mask(LB), r_acc, exp_chain(LB)); end
        sel = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_load();
        int nsh, idx;
        logic xfer;
        sel = 1'b0;
        run_probe(LA, -1);
        words = '{8'($urandom), 8'($urandom)};
        nsh = 0; idx = 0;
        for (int c = 0; c < 60; c++) begin
            if (pce_s) nsh++;
            if (nsh == 7) break;
            wvalid = 1'b1; wdata = words[idx];
            xfer = ready_s;
            @(posedge clk);
            if (xfer && idx < 1) idx++;
            @(negedge clk);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (nsh !== 7) begin n_fail++; $display("FAIL mid_reach got=%0d exp=7", nsh); end
        n_cmp++; if ({head_a, pce_a, if_a.word_ready, busy_a, done_a, err_a} !== 6'b0) begin n_fail++; $display("FAIL mid_reset got=%b exp=000000", {head_a, pce_a, if_a.word_ready, busy_a, done_a, err_a}); end
        @(negedge clk);
        rst_n = 1'b1; wvalid = 1'b0;
        check_quiet("mid_reset");
        run_probe(LA, 2);
        n_cmp++; if (p_nsh !== LA || p_nhead !== 1 || p_load !== 1'b1) begin n_fail++; $display("FAIL restart_ignored got=%0d/%0d/%b exp=%0d/1/1", p_nsh, p_nhead, p_load, LA); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_probe_ok();
        test_back_to_back();
        test_short_chain();
        test_long_chain();
        test_stall();
        test_random();
        test_partial_word();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
